// File: rtl/main_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | main_mem_ctrl: word-addressed main-memory model behind an in-order       |
// | request FIFO; returns one word per request after a fixed latency.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module main_mem_ctrl #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4,
  parameter int REQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        main_mem_req,
  input  logic [31:0] main_mem_addr,
  output logic        main_mem_ready,
  output logic [31:0] main_mem_data,
  output logic        req_full,
  output logic        busy,
  output logic        overflow_err,
  input  logic        init_we,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_data
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(REQ_DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0]   mem_q  [MEM_WORDS];
  logic [AW-1:0] fifo_q [REQ_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] word_q;
  logic [31:0]   data_q;
  logic          ovf_q;

  logic [AW-1:0] w_req_word, w_init_word;
  logic          w_full, w_empty, w_push, w_pop, w_read;
  logic          unused_addr_bits;

  assign w_req_word  = main_mem_addr[AW+1:2];
  assign w_init_word = init_addr[AW+1:2];
  assign unused_addr_bits = ^{main_mem_addr[31:AW+2], main_mem_addr[1:0],
                              init_addr[31:AW+2], init_addr[1:0]};

  assign w_full  = (count_q == (PW+1)'(REQ_DEPTH));
  assign w_empty = (count_q == '0);
  assign w_push  = main_mem_req & ~w_full;
  assign w_pop   = (state_q == S_IDLE) & ~w_empty;
  assign w_read  = (state_q == S_BUSY) && (cnt_q == '0);

  // Backing array and FIFO storage carry no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (init_we) mem_q[w_init_word] <= init_data;
    if (w_push)  fifo_q[wptr_q] <= w_req_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (w_push) wptr_q <= wptr_q + PW'(1);
      if (w_pop) begin
        rptr_q <= rptr_q + PW'(1);
        word_q <= fifo_q[rptr_q];
        cnt_q  <= CW'(LATENCY - 1);
      end else if ((state_q == S_BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      // Array read samples pre-edge contents, so a same-edge preload is not seen.
      if (w_read) data_q <= mem_q[word_q];
      if (main_mem_req && w_full) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!w_empty) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    main_mem_ready = (state_q == S_RESP);
    main_mem_data  = main_mem_ready ? data_q : 32'd0;
    req_full       = w_full;
    busy           = (state_q != S_IDLE) | ~w_empty;
    overflow_err   = ovf_q;
  end

endmodule
`default_nettype wire
